// File: rtl/gpio_wiggler_pkg.sv
// Shared pattern-mode encodings for the GPIO pattern generator.
// Latency: n/a (constants only).
// Backpressure: n/a.
package gpio_wiggler_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD   = 3'd0;
    localparam logic [MODE_W-1:0] MODE_ROTL   = 3'd1;
    localparam logic [MODE_W-1:0] MODE_ROTR   = 3'd2;
    localparam logic [MODE_W-1:0] MODE_BOUNCE = 3'd3;
    localparam logic [MODE_W-1:0] MODE_COUNT  = 3'd4;
    localparam logic [MODE_W-1:0] MODE_TOGGLE = 3'd5;

endpackage

// File: rtl/wiggle_prescaler.sv
// Step prescaler: counts 0..div and raises tick on the terminal count.
// Latency: tick is combinational from the registered count (same cycle).
// Backpressure: none; enable low freezes the count, clear forces it to 0.
module wiggle_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] pcnt;

    // A div lowered below pcnt is not caught: pcnt runs on and wraps mod 2^DIV_W.
    assign tick = enable && (pcnt == div);

    // Prescale counter; clear (load) wins over tick so the coincident tick is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (clear) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else if (enable) begin
            pcnt <= pcnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/gpio_wiggler.sv
// Programmable GPIO pattern generator with step and pattern-cycle strobes.
// Latency: 1 cycle from prescaler tick (or load) to gpio/step/wrap.
// Backpressure: none; enable low freezes the pattern, load always wins.
module gpio_wiggler
    import gpio_wiggler_pkg::*;
#(
    parameter int               WIDTH         = 32,
    parameter int               DIV_W         = 24,
    parameter logic [WIDTH-1:0] RESET_PATTERN = {{(WIDTH-1){1'b1}}, 1'b0}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [MODE_W-1:0] mode,
    input  logic [DIV_W-1:0]  div,
    input  logic [WIDTH-1:0]  seed,
    input  logic              load,
    output logic [WIDTH-1:0]  gpio,
    output logic              step,
    output logic              wrap
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] SCNT_LAST = SW'(WIDTH - 1);
    localparam logic [SW-1:0] SCNT_TURN = SW'(WIDTH - 2);

    logic             tick;
    logic [SW-1:0]    scnt;
    logic             dir;
    logic [WIDTH-1:0] rot_l;
    logic [WIDTH-1:0] rot_r;
    logic [SW-1:0]    scnt_adv;
    logic             scnt_last;
    logic             scnt_turn;

    wiggle_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .clear  (load),
        .div    (div),
        .tick   (tick)
    );

    assign rot_l     = {gpio[WIDTH-2:0], gpio[WIDTH-1]};
    assign rot_r     = {gpio[0], gpio[WIDTH-1:1]};
    assign scnt_last = (scnt == SCNT_LAST);
    assign scnt_turn = (scnt == SCNT_TURN);
    assign scnt_adv  = scnt_last ? '0 : scnt + SW'(1);

    // Pattern, step counter, direction and strobes; step marks every tick,
    // including HOLD ticks where the visible value does not change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio <= RESET_PATTERN;
            scnt <= '0;
            dir  <= 1'b0;
            step <= 1'b0;
            wrap <= 1'b0;
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;
            if (load) begin
                gpio <= seed;
                scnt <= '0;
                dir  <= 1'b0;
            end else if (tick) begin
                step <= 1'b1;
                case (mode)
                    MODE_ROTL: begin
                        gpio <= rot_l;
                        scnt <= scnt_adv;
                        wrap <= scnt_last;
                    end
                    MODE_ROTR: begin
                        gpio <= rot_r;
                        scnt <= scnt_adv;
                        wrap <= scnt_last;
                    end
                    MODE_TOGGLE: begin
                        gpio <= ~gpio;
                        scnt <= scnt_adv;
                        wrap <= scnt_last;
                    end
                    MODE_BOUNCE: begin
                        gpio <= dir ? rot_r : rot_l;
                        if (scnt_turn) begin
                            // Each leg is WIDTH-1 steps; the right-to-left
                            // turn puts the pattern back at its start.
                            dir  <= ~dir;
                            scnt <= '0;
                            wrap <= dir;
                        end else begin
                            scnt <= scnt + SW'(1);
                        end
                    end
                    MODE_COUNT: begin
                        gpio <= gpio + WIDTH'(1);
                        wrap <= &gpio;
                    end
                    default: begin
                        // HOLD and the unused codes leave everything as is.
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/gpio_wiggler.md
# gpio_wiggler

Parametrised GPIO pattern generator for board bring-up and fixture testing. It replaces the fixed 32-bit rotate-on-counter scheme with a programmable prescaler, a selectable pattern mode, run-time seed loading and per-step and per-cycle strobes. One instance drives each GPIO bank. It runs in the 125 MHz PCIe system clock domain.

## Interface
Parameters:
- WIDTH, 32, pattern and GPIO width; legal range 2..64.
- DIV_W, 24, prescaler width.
- RESET_PATTERN, {WIDTH-1{1'b1},1'b0}, value of gpio after reset; default is all ones with bit 0 low.

Ports:
- clk  in  1  pattern clock.
- rst  in  1  reset rst, asynchronous, active-high; clock clk.
- enable  in  1  high: prescaler runs; low: prescaler and pattern frozen.
- mode  in  3  pattern mode, sampled on each step.
- div  in  DIV_W  step period minus one, in clk cycles.
- seed  in  WIDTH  value loaded by load.
- load  in  1  single-cycle synchronous load request.
- gpio  out  WIDTH  registered pattern.
- step  out  1  one-cycle pulse, high in the first cycle a new gpio value is visible.
- wrap  out  1  one-cycle pulse marking completion of a pattern cycle; coincides with step.

## Operation
- Prescaler pcnt (DIV_W bits) counts 0..div while enable is high.
- The internal strobe tick is high when pcnt==div and enable is high. On tick, pcnt returns to 0.
- If div is lowered below the current pcnt, pcnt wraps through its full range modulo 2^DIV_W. This case is not corrected.
- A step counter scnt counts 0..WIDTH-1 and has $clog2(WIDTH) bits. A direction flag dir uses 0=left, 1=right.
- On tick, gpio updates according to mode:
  - 0 HOLD: gpio unchanged, scnt unchanged, wrap never set.
  - 1 ROTL: gpio <= {gpio[WIDTH-2:0], gpio[WIDTH-1]}.
  - 2 ROTR: gpio <= {gpio[0], gpio[WIDTH-1:1]}.
  - 3 BOUNCE: rotate left while dir=0 and rotate right while dir=1.
  - 4 COUNT: gpio <= gpio+1, modulo 2^WIDTH.
  - 5 TOGGLE: gpio <= ~gpio.
  - 6, 7: treated as HOLD.
- scnt and wrap, ROTL/ROTR/TOGGLE:
  - scnt increments on each tick.
  - At scnt==WIDTH-1, scnt returns to 0 and wrap fires.
  - For TOGGLE, wrap therefore fires every WIDTH toggles.
- scnt, dir and wrap, BOUNCE:
  - At scnt==WIDTH-2, dir inverts and scnt returns to 0, so each leg is WIDTH-1 steps.
  - wrap fires on the right-to-left reversal, i.e. the pattern is back at its start position.
- wrap, COUNT: fires when gpio goes from all ones to 0. scnt is unused in this mode.
- Load:
  - load=1 forces gpio<=seed, pcnt<=0, scnt<=0, dir<=0 regardless of enable.
  - No step or wrap pulse is produced for the load cycle.
  - load has priority over a coincident tick; that tick is discarded.
- Mode change: takes effect at the next tick. scnt and dir are not cleared; firmware issues load for a clean start.
- enable low: pcnt, scnt, dir and gpio hold. step and wrap stay 0.

## Timing
- All outputs are registered. Reset values: gpio=RESET_PATTERN, step=0, wrap=0. Internal reset values: pcnt=0, scnt=0, dir=0.
- Step period is div+1 clk cycles. div=0 gives a step every cycle.
- First tick after reset release with enable high: at cycle div. The new gpio value and step are visible at cycle div+1.
- Latency: tick to gpio/step/wrap is 1 cycle. load to gpio=seed is 1 cycle.
- Asserting rst mid-operation returns every register to its reset value immediately. Operation restarts at pcnt=0 after release.
- Inputs mode, div and seed are synchronous to clk. No CDC is performed inside the block.

## Structure
- Package gpio_wiggler_pkg holds the mode localparams: MODE_HOLD, MODE_ROTL, MODE_ROTR, MODE_BOUNCE, MODE_COUNT, MODE_TOGGLE, with widths.
- Sub-module wiggle_prescaler (parameter DIV_W) contains pcnt and produces tick from enable, div and a clear input driven by load.
- The top level contains the pattern register, scnt, dir and the output registers.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold rst high, then release. Required: gpio=0xFE, step=0, wrap=0. With mode=ROTL, div=3, enable=1: gpio=0xFD visible at cycle 4 with step high.
- ROTL, div=0, seed=0x01 loaded: gpio steps 0x02, 0x04 … 0x80, 0x01. wrap is high exactly when 0x01 reappears, i.e. step 8.
- BOUNCE, div=0, seed=0x01: gpio follows 0x02..0x80 and then 0x40..0x01. wrap fires on return to 0x01 after 14 steps, and the sequence repeats.
- COUNT, div=1, seed=0xFE: 0xFF after 2 cycles, 0x00 after 2 more with wrap high. step fires every 2 cycles.
- load coincident with tick, ROTL, seed=0xA5: gpio=0xA5 next cycle with step=0. The next update occurs div+1 cycles later.
- enable dropped mid-period, then rst asserted for one cycle while running: gpio, step and scnt are frozen while enable is low. rst returns gpio to 0xFE asynchronously without waiting for a clock edge.
